// File: rtl/warp_scheduler_pkg.sv
// Shared types for the warp scheduler slice: per-warp instruction state and datapath width.
// Optional feature macro used by this slice: SCHED_PERF_CNT_EN (stall-cycle counter).
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package warp_scheduler_pkg;

    typedef enum logic [2:0] {
        WARP_IDLE,
        WARP_FETCH,
        WARP_DECODE,
        WARP_REQUEST,
        WARP_WAIT,
        WARP_EXECUTE,
        WARP_UPDATE,
        WARP_DONE
    } warp_state_t;

endpackage

// File: rtl/warp_scheduler_if.sv
// Dispatcher/pipeline-facing bundle of the warp scheduler; stall_cycles exists only
// when SCHED_PERF_CNT_EN is defined.
interface warp_scheduler_if #(
    parameter int NUM_WARPS = 4
);
    import warp_scheduler_pkg::*;

    localparam int WARP_ID_WIDTH = $clog2(NUM_WARPS);

    logic                     start;
    logic [WARP_ID_WIDTH:0]   active_warps;
    logic                     fetch_done;
    logic                     decoded_mem_op;
    logic                     decoded_halt;
    logic                     lsu_done;
    logic [NUM_WARPS-1:0]     warp_enable;
    warp_state_t              warp_state [NUM_WARPS];
    logic [WARP_ID_WIDTH-1:0] cur_warp;
    logic                     block_done;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0]              stall_cycles;
`endif

    modport master (
        output start, active_warps, fetch_done, decoded_mem_op, decoded_halt, lsu_done,
        input  warp_enable, warp_state, cur_warp, block_done
`ifdef SCHED_PERF_CNT_EN
        , input stall_cycles
`endif
    );

    modport slave (
        input  start, active_warps, fetch_done, decoded_mem_op, decoded_halt, lsu_done,
        output warp_enable, warp_state, cur_warp, block_done
`ifdef SCHED_PERF_CNT_EN
        , output stall_cycles
`endif
    );

endinterface

// File: rtl/warp_scheduler_rr_next_warp.sv
// Combinational round-robin search: first set bit of not_done after cur, modulo count,
// wrapping back onto cur itself; none_left when no bit is set.
module rr_next_warp #(
    parameter int NUM_WARPS     = 4,
    parameter int WARP_ID_WIDTH = $clog2(NUM_WARPS)
) (
    input  logic [NUM_WARPS-1:0]     not_done,
    input  logic [WARP_ID_WIDTH-1:0] cur,
    input  logic [WARP_ID_WIDTH:0]   count,
    output logic [WARP_ID_WIDTH-1:0] next,
    output logic                     none_left
);
    localparam logic [WARP_ID_WIDTH:0] ONE = 1;

    logic [WARP_ID_WIDTH:0] idx;
    logic [WARP_ID_WIDTH:0] idx_inc;
    logic                   found;

    // Walk NUM_WARPS candidates; when count < NUM_WARPS the walk simply revisits indices.
    always_comb begin
        idx       = {1'b0, cur};
        idx_inc   = '0;
        next      = cur;
        found     = 1'b0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            idx_inc = idx + ONE;
            idx     = (idx_inc >= count) ? '0 : idx_inc;
            if (!found && not_done[idx[WARP_ID_WIDTH-1:0]]) begin
                found = 1'b1;
                next  = idx[WARP_ID_WIDTH-1:0];
            end
        end
        none_left = !found;
    end

endmodule

// File: rtl/warp_scheduler.sv
// Round-robin warp scheduler: launches a block of warps and steps one selected warp at a
// time through the instruction sequence. SCHED_PERF_CNT_EN adds the stall_cycles counter.
module warp_scheduler
    import warp_scheduler_pkg::*;
#(
    parameter int NUM_WARPS     = 4,
    parameter int WARP_ID_WIDTH = $clog2(NUM_WARPS)
) (
    input  logic             clk,
    input  logic             reset,
    warp_scheduler_if.slave  bus
);
    localparam logic [WARP_ID_WIDTH:0] MAX_WARPS = (WARP_ID_WIDTH + 1)'(NUM_WARPS);

    warp_state_t              state_q [NUM_WARPS];
    warp_state_t              state_d [NUM_WARPS];
    logic [WARP_ID_WIDTH-1:0] cur_q, cur_d;
    logic [WARP_ID_WIDTH:0]   num_q, num_d;
    logic                     done_q, done_d;
    logic [NUM_WARPS-1:0]     live_mask;
    logic [NUM_WARPS-1:0]     not_done_mask;
    logic [NUM_WARPS-1:0]     enable;
    logic [WARP_ID_WIDTH:0]   clamped;
    logic [WARP_ID_WIDTH-1:0] next_warp;
    logic                     none_left;
    logic                     any_live;
    logic                     cur_live;
    logic                     launch;

    // The mask feeds the rotation search with the selected warp's post-UPDATE liveness,
    // derived from decoded_halt directly so it does not depend on state_d.
    always_comb begin
        live_mask     = '0;
        not_done_mask = '0;
        for (int j = 0; j < NUM_WARPS; j++) begin
            live_mask[j]     = (state_q[j] != WARP_IDLE) && (state_q[j] != WARP_DONE);
            not_done_mask[j] = live_mask[j];
        end
        not_done_mask[cur_q] = !bus.decoded_halt;
    end

    assign any_live = |live_mask;
    assign cur_live = live_mask[cur_q];
    assign launch   = bus.start && !any_live;
    assign clamped  = (bus.active_warps > MAX_WARPS) ? MAX_WARPS : bus.active_warps;

    rr_next_warp #(
        .NUM_WARPS     (NUM_WARPS),
        .WARP_ID_WIDTH (WARP_ID_WIDTH)
    ) u_rr_next_warp (
        .not_done  (not_done_mask),
        .cur       (cur_q),
        .count     (num_q),
        .next      (next_warp),
        .none_left (none_left)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < NUM_WARPS; j++) begin
                state_q[j] <= WARP_IDLE;
            end
            cur_q  <= '0;
            num_q  <= '0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            num_q   <= num_d;
            done_q  <= done_d;
        end
    end

    // Only the selected warp advances; a zero-warp launch reports completion immediately.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        num_d   = num_q;
        done_d  = done_q;
        if (launch) begin
            num_d  = clamped;
            cur_d  = '0;
            done_d = (clamped == '0);
            for (int j = 0; j < NUM_WARPS; j++) begin
                state_d[j] = ((WARP_ID_WIDTH + 1)'(j) < clamped) ? WARP_FETCH : WARP_IDLE;
            end
        end else if (cur_live) begin
            case (state_q[cur_q])
                WARP_FETCH:   if (bus.fetch_done) state_d[cur_q] = WARP_DECODE;
                WARP_DECODE:  state_d[cur_q] = WARP_REQUEST;
                WARP_REQUEST: state_d[cur_q] = bus.decoded_mem_op ? WARP_WAIT : WARP_EXECUTE;
                WARP_WAIT:    if (bus.lsu_done) state_d[cur_q] = WARP_EXECUTE;
                WARP_EXECUTE: state_d[cur_q] = WARP_UPDATE;
                WARP_UPDATE: begin
                    state_d[cur_q] = bus.decoded_halt ? WARP_DONE : WARP_FETCH;
                    if (none_left) begin
                        done_d = 1'b1;
                    end else begin
                        cur_d = next_warp;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        enable = '0;
        if (cur_live) begin
            enable[cur_q] = 1'b1;
        end
    end

    assign bus.warp_enable = enable;
    assign bus.warp_state  = state_q;
    assign bus.cur_warp    = cur_q;
    assign bus.block_done  = done_q;

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] stall_q;
    logic        stall;

    assign stall = cur_live &&
                   (((state_q[cur_q] == WARP_FETCH) && !bus.fetch_done) ||
                    ((state_q[cur_q] == WARP_WAIT)  && !bus.lsu_done));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (launch) begin
            stall_q <= '0;
        end else if (stall && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign bus.stall_cycles = stall_q;
`endif

endmodule
